// File: rtl/joybus_pkg.sv
// Joybus line codec shared definitions: FSM states, quarter-count timing
// constants, error codes and the data CRC polynomial/update helper.
package joybus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_LOAD,
    ST_TX_BIT,
    ST_TX_STOP,
    ST_RX_WAIT,
    ST_RX_BIT,
    ST_RX_STOP
  } state_e;

  // Line timing, all in quarter-bit units
  localparam int unsigned TX_BIT_Q     = 4;  // quarters per transmitted bit
  localparam int unsigned TX_STOP_Q    = 3;  // host stop: 1 low + 2 high
  localparam int unsigned TX_LOW1_Q    = 1;  // low quarters for a '1'
  localparam int unsigned TX_LOW0_Q    = 3;  // low quarters for a '0'
  localparam int unsigned RX_SAMPLE_Q  = 2;  // sample point after falling edge
  localparam int unsigned RX_EDGE_Q    = 6;  // window for the next falling edge
  localparam int unsigned RX_STOP_HI_Q = 2;  // idle-high time closing a reply

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_UNDERRUN = 2'b10;
  localparam logic [1:0] ERR_FRAMING  = 2'b11;

  localparam logic [7:0] CRC_POLY = 8'h85;

  // MSB-first CRC-8 update of one byte, no reflection, no final xor
  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/joybus_crc8.sv
// Byte-serial Joybus data CRC-8 accumulator (poly 0x85, init 0x00).
module joybus_crc8
  import joybus_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_l_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  // Accumulate one byte per enable; clear at the start of each transaction
  always_ff @(posedge clk_i) begin
    if (!reset_l_i) begin
      crc_q <= '0;
    end else if (clear_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc8_update(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/joybus_line_codec.sv
// Joybus physical stage for one joy port: serialises command bytes with
// pulse-width coding onto an open-drain line, then times and decodes the
// controller reply into bytes.
// Optional: define JOYBUS_CRC_EN to compute the reply data CRC on rx_crc.
module joybus_line_codec
  import joybus_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned TIMEOUT_Q = 256,
  parameter int unsigned LEN_W     = 6
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [LEN_W-1:0] rx_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_pop,
  output logic [7:0]       rx_data,
  output logic             rx_push,
  output logic             joy_oe,
  input  logic             joy_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic [7:0]       rx_crc
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned QW = ($clog2(TIMEOUT_Q + 1) > 3) ? $clog2(TIMEOUT_Q + 1) : 3;

  state_e           state_q;
  logic [PW-1:0]    presc_q;
  logic [QW-1:0]    qcnt_q;
  logic [2:0]       bitc_q;
  logic [LEN_W-1:0] txc_q, rxc_q;
  logic [LEN_W-1:0] tx_len_q, rx_len_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             tx_pop_q, rx_push_q, joy_oe_q, busy_q, done_q;
  logic [1:0]       err_q;
  logic [2:0]       sync_q;
  logic [1:0]       stop_ph_q;
  logic             sampled_q;

  logic             q_tick, line_s, fall, rise, start_acc;
  logic [QW-1:0]    tx_low;

  // Quarter tick, synchronised line edges and transmit low-time decode
  always_comb begin
    q_tick    = (presc_q == PW'(CLK_DIV - 1));
    line_s    = sync_q[1];
    fall      = sync_q[2] & ~sync_q[1];
    rise      = ~sync_q[2] & sync_q[1];
    tx_low    = shift_q[7] ? QW'(TX_LOW1_Q) : QW'(TX_LOW0_Q);
    start_acc = (state_q == ST_IDLE) && start && !busy_q;
  end

  // Transaction FSM with registered line drive, strobes and status
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      qcnt_q    <= '0;
      bitc_q    <= '0;
      txc_q     <= '0;
      rxc_q     <= '0;
      tx_len_q  <= '0;
      rx_len_q  <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      tx_pop_q  <= 1'b0;
      rx_push_q <= 1'b0;
      joy_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
      sync_q    <= '1;
      stop_ph_q <= '0;
      sampled_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], joy_in};
      tx_pop_q  <= 1'b0;
      rx_push_q <= 1'b0;
      done_q    <= 1'b0;
      presc_q   <= q_tick ? '0 : presc_q + 1'b1;
      if (q_tick) qcnt_q <= qcnt_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          // busy stays high through the done cycle, so a start there is ignored
          presc_q  <= '0;
          qcnt_q   <= '0;
          joy_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          if (start_acc) begin
            busy_q   <= 1'b1;
            err_q    <= ERR_OK;
            tx_len_q <= tx_len;
            rx_len_q <= rx_len;
            txc_q    <= '0;
            rxc_q    <= '0;
            if (tx_len == '0) begin
              joy_oe_q <= 1'b1;
              state_q  <= ST_TX_STOP;
            end else begin
              state_q  <= ST_TX_LOAD;
            end
          end
        end

        ST_TX_LOAD: begin
          presc_q <= '0;
          qcnt_q  <= '0;
          bitc_q  <= '0;
          if (tx_valid) begin
            tx_pop_q <= 1'b1;
            shift_q  <= tx_data;
            joy_oe_q <= 1'b1;
            state_q  <= ST_TX_BIT;
          end else begin
            err_q    <= ERR_UNDERRUN;
            joy_oe_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end

        ST_TX_BIT: begin
          if (q_tick) begin
            if (qcnt_q == QW'(TX_BIT_Q - 1)) begin
              qcnt_q <= '0;
              if (bitc_q == 3'd7) begin
                txc_q <= txc_q + 1'b1;
                if ((txc_q + 1'b1) == tx_len_q) begin
                  joy_oe_q <= 1'b1;
                  state_q  <= ST_TX_STOP;
                end else begin
                  joy_oe_q <= 1'b0;
                  state_q  <= ST_TX_LOAD;
                end
              end else begin
                bitc_q   <= bitc_q + 3'd1;
                shift_q  <= {shift_q[6:0], 1'b0};
                joy_oe_q <= 1'b1;
              end
            end else begin
              joy_oe_q <= ((qcnt_q + 1'b1) < tx_low);
            end
          end
        end

        ST_TX_STOP: begin
          if (q_tick) begin
            joy_oe_q <= 1'b0;
            if (qcnt_q == QW'(TX_STOP_Q - 1)) begin
              qcnt_q <= '0;
              if (rx_len_q == '0) begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_RX_WAIT;
              end
            end
          end
        end

        ST_RX_WAIT: begin
          if (fall) begin
            presc_q   <= '0;
            qcnt_q    <= '0;
            bitc_q    <= '0;
            sampled_q <= 1'b0;
            state_q   <= ST_RX_BIT;
          end else if (q_tick && qcnt_q == QW'(TIMEOUT_Q - 1)) begin
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        ST_RX_BIT: begin
          // the bit window restarts at each accepted falling edge; edges before the sample point are ignored
          if (fall && sampled_q) begin
            presc_q   <= '0;
            qcnt_q    <= '0;
            sampled_q <= 1'b0;
          end else if (q_tick) begin
            if (!sampled_q && qcnt_q == QW'(RX_SAMPLE_Q - 1)) begin
              sampled_q <= 1'b1;
              shift_q   <= {shift_q[6:0], line_s};
              bitc_q    <= bitc_q + 3'd1;
              if (bitc_q == 3'd7) begin
                rx_push_q <= 1'b1;
                rx_data_q <= {shift_q[6:0], line_s};
                rxc_q     <= rxc_q + 1'b1;
                if ((rxc_q + 1'b1) == rx_len_q) begin
                  stop_ph_q <= 2'd0;
                  state_q   <= ST_RX_STOP;
                end
              end
            end else if (qcnt_q == QW'(RX_EDGE_Q - 1)) begin
              err_q   <= ERR_FRAMING;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end

        ST_RX_STOP: begin
          // phase 0: stop falling edge (window still timed from last bit start),
          // phase 1: stop pulse low, phase 2: line must stay high
          case (stop_ph_q)
            2'd0: begin
              if (fall) begin
                presc_q   <= '0;
                qcnt_q    <= '0;
                stop_ph_q <= 2'd1;
              end else if (q_tick && qcnt_q == QW'(RX_EDGE_Q - 1)) begin
                err_q   <= ERR_FRAMING;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            2'd1: begin
              if (rise) begin
                presc_q   <= '0;
                qcnt_q    <= '0;
                stop_ph_q <= 2'd2;
              end else if (q_tick && qcnt_q == QW'(RX_EDGE_Q - 1)) begin
                err_q   <= ERR_FRAMING;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            default: begin
              if (fall) begin
                err_q   <= ERR_FRAMING;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else if (q_tick && qcnt_q == QW'(RX_STOP_HI_Q - 1)) begin
                err_q   <= ERR_OK;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
          endcase
        end

        default: begin
          joy_oe_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_pop  = tx_pop_q;
  assign rx_data = rx_data_q;
  assign rx_push = rx_push_q;
  assign joy_oe  = joy_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

`ifdef JOYBUS_CRC_EN
  joybus_crc8 u_crc (
    .clk_i     (clk),
    .reset_l_i (reset_l),
    .clear_i   (start_acc),
    .en_i      (rx_push_q),
    .data_i    (rx_data_q),
    .crc_o     (rx_crc)
  );
`else
  assign rx_crc = '0;
`endif

endmodule

// File: tb/tb_joybus_line_codec.sv
// Scoreboard bench for joybus_line_codec with a behavioural controller on the line.
module tb_joybus_line_codec;

  logic       clk = 1'b0;
  logic       reset_l, start;
  logic [5:0] tx_len, rx_len;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_pop, rx_push, joy_oe, busy, done;
  logic [7:0] rx_data, rx_crc;
  logic [1:0] err;
  logic       dev_low, model_kill;
  logic       joy_in;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  int run_len  = 0;
  int el;

  logic [7:0] txq         [$];
  logic [7:0] model_bytes [$];
  logic [7:0] rx_exp_q    [$];
  logic [1:0] done_exp_q  [$];
  int         width_exp_q [$];
  logic [7:0] mon_rx_e;
  logic [1:0] mon_err_e;
  int         mon_w_e;

  always #5 clk = ~clk;

  // open-drain line with pull-up: low if host or controller pulls it
  assign joy_in = ~(joy_oe | dev_low);

  joybus_line_codec #(.CLK_DIV(4), .TIMEOUT_Q(256), .LEN_W(6)) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .tx_len(tx_len), .rx_len(rx_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop), .rx_data(rx_data),
    .rx_push(rx_push), .joy_oe(joy_oe), .joy_in(joy_in), .busy(busy), .done(done),
    .err(err), .rx_crc(rx_crc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // TX FIFO model: pop on strobe, present head byte
  always @(posedge clk) begin
    if (tx_pop && txq.size() != 0) begin
      void'(txq.pop_front());
      pop_cnt++;
    end
    tx_valid <= (txq.size() != 0);
    tx_data  <= (txq.size() != 0) ? txq[0] : 8'h00;
  end

  // Monitor: received bytes and transaction completions against the scoreboard
  always @(negedge clk) begin
    if (reset_l === 1'b1) begin
      if (rx_push) begin
        if (rx_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx_push_unexpected: got byte %0h, required no push", rx_data);
        end else begin
          mon_rx_e = rx_exp_q.pop_front();
          chk("rx_data", {24'h0, rx_data}, {24'h0, mon_rx_e});
        end
      end
      if (done) begin
        if (done_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got done err=%0d, required no done", err);
        end else begin
          mon_err_e = done_exp_q.pop_front();
          chk("done_err", {30'h0, err}, {30'h0, mon_err_e});
          chk("busy_at_done", {31'h0, busy}, 32'd1);
        end
      end
    end
  end

  // Monitor: host low-pulse widths in clocks
  always @(negedge clk) begin
    if (reset_l !== 1'b1) begin
      run_len = 0;
    end else if (joy_oe) begin
      run_len++;
    end else if (run_len > 0) begin
      if (width_exp_q.size() != 0) begin
        mon_w_e = width_exp_q.pop_front();
        chk("tx_low_width", run_len, mon_w_e);
      end
      run_len = 0;
    end
  end

  task automatic fifo_push(input logic [7:0] b);
    txq.push_back(b);
    tx_valid = 1'b1;
    tx_data  = txq[0];
  endtask

  task automatic do_start(input logic [5:0] tl, input logic [5:0] rl);
    @(posedge clk); #1;
    tx_len = tl; rx_len = rl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < limit);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", limit);
    end
  endtask

  // Controller model: waits for the host command + stop, then replies
  task automatic ctrl_reply(input int ntx, input bit send_stop);
    int   rel;
    int   cyc;
    logic prev;
    logic v;
    rel = 0; cyc = 0; prev = 1'b0;
    while (rel < ntx * 8 + 1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (prev && !joy_oe) rel++;
      prev = joy_oe;
    end
    if (rel < ntx * 8 + 1) begin
      n_checks++; n_fail++;
      $display("FAIL model_wait_cmd: got %0d host pulses, required %0d", rel, ntx * 8 + 1);
      return;
    end
    repeat (16) @(negedge clk);
    foreach (model_bytes[i]) begin
      for (int b = 7; b >= 0; b--) begin
        if (model_kill) begin
          dev_low = 1'b0;
          return;
        end
        v = model_bytes[i][b];
        dev_low = 1'b1;
        repeat (v ? 4 : 12) @(negedge clk);
        dev_low = 1'b0;
        repeat (v ? 12 : 4) @(negedge clk);
      end
    end
    if (send_stop && !model_kill) begin
      dev_low = 1'b1;
      repeat (8) @(negedge clk);
      dev_low = 1'b0;
    end
  endtask

  task automatic status_read();
    int p0;
    p0 = pop_cnt;
    fifo_push(8'h01);
    model_bytes = '{8'h10, 8'h30, 8'h05, 8'h04};
    rx_exp_q.push_back(8'h10); rx_exp_q.push_back(8'h30);
    rx_exp_q.push_back(8'h05); rx_exp_q.push_back(8'h04);
    done_exp_q.push_back(2'b00);
    fork
      ctrl_reply(1, 1'b1);
      begin
        do_start(6'd1, 6'd4);
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(3000, el);
      end
    join
    repeat (4) @(negedge clk);
    chk("status_pops", pop_cnt - p0, 1);
    chk("status_err_held", {30'h0, err}, 32'd0);
    chk("status_rx_all", rx_exp_q.size(), 0);
    chk("status_oe_idle", {31'h0, joy_oe}, 32'd0);
    chk("status_busy_idle", {31'h0, busy}, 32'd0);
`ifndef JOYBUS_CRC_EN
    chk("crc_tied_zero", {24'h0, rx_crc}, 32'h0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b0; start = 1'b0; tx_len = '0; rx_len = '0;
    tx_valid = 1'b0; tx_data = '0; dev_low = 1'b0; model_kill = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_l = 1'b1;
    @(negedge clk);
    chk("rst_busy",    {31'h0, busy},    32'd0);
    chk("rst_done",    {31'h0, done},    32'd0);
    chk("rst_joy_oe",  {31'h0, joy_oe},  32'd0);
    chk("rst_err",     {30'h0, err},     32'd0);
    chk("rst_tx_pop",  {31'h0, tx_pop},  32'd0);
    chk("rst_rx_push", {31'h0, rx_push}, 32'd0);
    chk("rst_rx_data", {24'h0, rx_data}, 32'd0);
    chk("rst_rx_crc",  {24'h0, rx_crc},  32'd0);

    // controller status read
    status_read();

    // TX pulse coding of 0xA5 plus host stop, and first-drive latency
    begin
      int p0;
      p0 = pop_cnt;
      fifo_push(8'hA5);
      width_exp_q = '{4, 12, 4, 12, 12, 4, 12, 4, 4};
      done_exp_q.push_back(2'b00);
      do_start(6'd1, 6'd0);
      chk("oe_latency_1clk", {31'h0, joy_oe}, 32'd0);
      @(posedge clk); #1;
      chk("oe_latency_2clk", {31'h0, joy_oe}, 32'd1);
      wait_done(400, el);
      repeat (3) @(negedge clk);
      chk("tx_widths_seen", width_exp_q.size(), 0);
      chk("tx_pops", pop_cnt - p0, 1);
    end

    // reply timeout, no device on the line
    fifo_push(8'h01);
    done_exp_q.push_back(2'b01);
    do_start(6'd1, 6'd4);
    wait_done(2000, el);
    chk("timeout_latency_window", {31'h0, (el >= 1160 && el <= 1170)}, 32'd1);
    repeat (5) @(negedge clk);
    chk("timeout_err_held", {30'h0, err}, 32'd1);
    chk("timeout_oe", {31'h0, joy_oe}, 32'd0);

    // TX underrun: three bytes requested, two queued
    begin
      int p0;
      p0 = pop_cnt;
      fifo_push(8'h11); fifo_push(8'h22);
      done_exp_q.push_back(2'b10);
      do_start(6'd3, 6'd0);
      wait_done(1000, el);
      repeat (2) @(negedge clk);
      chk("underrun_pops", pop_cnt - p0, 2);
      chk("underrun_oe", {31'h0, joy_oe}, 32'd0);
      chk("underrun_busy", {31'h0, busy}, 32'd0);
    end

    // framing: two bytes expected, controller sends one and stops driving
    fifo_push(8'h01);
    model_bytes = '{8'h5A};
    rx_exp_q.push_back(8'h5A);
    done_exp_q.push_back(2'b11);
    fork
      ctrl_reply(1, 1'b0);
      begin
        do_start(6'd1, 6'd2);
        wait_done(3000, el);
      end
    join

    // reset during the second reply byte
    fifo_push(8'h01);
    model_bytes = '{8'h10, 8'h30, 8'h05, 8'h04};
    rx_exp_q.push_back(8'h10);
    fork
      ctrl_reply(1, 1'b1);
      begin
        int cyc;
        do_start(6'd1, 6'd4);
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!rx_push && cyc < 2000);
        chk("rst_mid_first_byte_seen", {31'h0, rx_push}, 32'd1);
        repeat (40) @(negedge clk);
        reset_l = 1'b0;
        model_kill = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_busy", {31'h0, busy}, 32'd0);
        chk("rst_mid_oe", {31'h0, joy_oe}, 32'd0);
        reset_l = 1'b1;
      end
    join
    model_kill = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_mid_no_busy", {31'h0, busy}, 32'd0);

    // next transaction after the abort works normally
    status_read();

`ifdef JOYBUS_CRC_EN
    fifo_push(8'h01);
    model_bytes.delete();
    for (int i = 0; i < 32; i++) begin
      model_bytes.push_back(8'h00);
      rx_exp_q.push_back(8'h00);
    end
    done_exp_q.push_back(2'b00);
    fork
      ctrl_reply(1, 1'b1);
      begin
        do_start(6'd1, 6'd32);
        wait_done(8000, el);
      end
    join
    chk("crc_32_zeros", {24'h0, rx_crc}, 32'h00);

    fifo_push(8'h01);
    model_bytes = '{8'h01};
    rx_exp_q.push_back(8'h01);
    done_exp_q.push_back(2'b00);
    fork
      ctrl_reply(1, 1'b1);
      begin
        do_start(6'd1, 6'd1);
        wait_done(2000, el);
      end
    join
    chk("crc_byte_01", {24'h0, rx_crc}, 32'h85);
`endif

    repeat (10) @(negedge clk);
    chk("end_rx_queue_empty", rx_exp_q.size(), 0);
    chk("end_done_queue_empty", done_exp_q.size(), 0);
    chk("end_tx_fifo_empty", txq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
